ram_responder: RTL and testbench

- Memory-side responder for the CPU RAM request/acknowledge bus: answers readReq/writeReq with readAck/writeAck using a four-phase handshake.
- Byte-addressed RAM of RAMSIZE bytes; every access moves one 32-bit little-endian word (bytes a..a+3).
- Sits between the CPU core and program/data storage; also used as the behavioural RAM in CPU benches.
- A byte-wide load port preloads programs before or between runs.

---
 rtl/ram_responder_if.sv | 29 ++
 rtl/ram_responder.sv | 119 +++++++++++
 tb/tb_ram_responder.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/ram_responder_if.sv
// CPU RAM request/acknowledge bus plus the byte-wide preload port.
// The master modport is the CPU side and the slave modport is the RAM side.
interface ram_responder_if;
  logic [7:0]  ramAddress;
  logic [31:0] writeData;
  logic        readReq;
  logic        writeReq;
  logic [31:0] readData;
  logic        readAck;
  logic        writeAck;
  logic        loadEn;
  logic [7:0]  loadAddr;
  logic [7:0]  loadData;
  logic        busy;

  // Four-phase handshake: the master raises a request and holds it and its address/data
  // until the matching ack is seen high. It then drops the request. The slave then drops
  // the ack on the first edge where the request is low. Dropping a request before its ack
  // cancels that request.
  modport master (
    output ramAddress, writeData, readReq, writeReq, loadEn, loadAddr, loadData,
    input  readData, readAck, writeAck, busy
  );

  modport slave (
    input  ramAddress, writeData, readReq, writeReq, loadEn, loadAddr, loadData,
    output readData, readAck, writeAck, busy
  );
endinterface

// File: rtl/ram_responder.sv
// Byte-addressed RAM that answers 32-bit little-endian read/write requests with a
// four-phase handshake after a fixed latency. It also accepts byte preloads at any time.
module ram_responder #(
  parameter int RAMSIZE       = 64,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 1
) (
  input  logic             clk,
  input  logic             reset,
  ram_responder_if.slave   bus,
  output logic [2:0]       state_o
);

  localparam int AW = $clog2(RAMSIZE);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_WAIT = 3'd1,
    RD_ACK  = 3'd2,
    WR_WAIT = 3'd3,
    WR_ACK  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        rd_done, wr_done, commit;
  logic [31:0] mem_word;
  logic [7:0]  mem_q [RAMSIZE];

  // Byte lane i of a word at address a; the sum wraps modulo RAMSIZE.
  function automatic logic [AW-1:0] byte_idx(input logic [7:0] a, input logic [1:0] i);
    return a[AW-1:0] + AW'(i);
  endfunction

  always_comb begin
    mem_word = '0;
    for (int i = 0; i < 4; i++) mem_word[8*i +: 8] = mem_q[byte_idx(addr_q, 2'(i))];
  end

  assign rd_done = bus.readReq  && (cnt_q == 4'(READ_LATENCY - 1));
  assign wr_done = bus.writeReq && (cnt_q == 4'(WRITE_LATENCY - 1));
  assign commit  = reset && (state_q == WR_WAIT) && wr_done;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.writeReq) begin
          addr_d  = bus.ramAddress;
          wdata_d = bus.writeData;
          cnt_d   = '0;
          state_d = WR_WAIT;
        end else if (bus.readReq) begin
          addr_d  = bus.ramAddress;
          cnt_d   = '0;
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (!bus.readReq) begin
          state_d = IDLE;
        end else if (rd_done) begin
          rdata_d = mem_word;
          state_d = RD_ACK;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RD_ACK:  if (!bus.readReq) state_d = IDLE;
      WR_WAIT: begin
        if (!bus.writeReq)  state_d = IDLE;
        else if (wr_done)   state_d = WR_ACK;
        else                cnt_d   = cnt_q + 4'd1;
      end
      WR_ACK:  if (!bus.writeReq) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.readAck  = (state_q == RD_ACK);
    bus.writeAck = (state_q == WR_ACK);
    bus.busy     = (state_q != IDLE);
    bus.readData = rdata_q;
    state_o      = state_q;
  end

  // Memory is never reset. A commit in the same cycle as a load overrides the loaded byte.
  always_ff @(posedge clk) begin
    if (bus.loadEn) mem_q[bus.loadAddr[AW-1:0]] <= bus.loadData;
    if (commit) begin
      for (int i = 0; i < 4; i++) mem_q[byte_idx(addr_q, 2'(i))] <= wdata_q[8*i +: 8];
    end
  end

endmodule

// File: tb/tb_ram_responder.sv
// Randomized bench for ram_responder. It compares the DUT against a byte-array model
// of the RAM and against the handshake timing rules.
module tb_ram_responder;
  localparam int RAMSIZE = 64;
  localparam int RL      = 2;
  localparam int WL      = 1;
  localparam int BOUND   = 20;

  logic       clk;
  logic       reset;
  logic [2:0] dbg_state;
  ram_responder_if bus();

  ram_responder #(.RAMSIZE(RAMSIZE), .READ_LATENCY(RL), .WRITE_LATENCY(WL)) dut (
    .clk(clk), .reset(reset), .bus(bus), .state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [7:0]  model_mem [RAMSIZE];
  logic [31:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_word(input int a);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = model_mem[(a + i) % RAMSIZE];
    return w;
  endfunction

  function automatic void model_write(input int a, input logic [31:0] d);
    for (int i = 0; i < 4; i++) model_mem[(a + i) % RAMSIZE] = d[8*i +: 8];
  endfunction

  // Wait one edge, then settle #1 so that samples and drives are away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_load(input logic [7:0] a, input logic [7:0] d);
    bus.loadEn = 1'b1; bus.loadAddr = a; bus.loadData = d;
    tick();
    bus.loadEn = 1'b0;
    model_mem[int'(a) % RAMSIZE] = d;
  endtask

  // Full read handshake. The request is raised right away, so it may follow a drop by one cycle.
  task automatic do_read(input logic [7:0] a);
    logic [31:0] exp;
    int n;
    exp = model_word(int'(a));
    exp_q.push_back(exp);
    bus.ramAddress = a; bus.readReq = 1'b1;
    n = 0;
    while (n < BOUND && !bus.readAck) begin
      tick(); n++;
      check("rd_no_wr_ack", 32'(bus.writeAck), 32'd0);
    end
    check("rd_latency", 32'(n), 32'(RL + 1));
    check("rd_data", bus.readData, exp_q.pop_front());
    tick();
    check("rd_ack_hold", 32'(bus.readAck), 32'd1);
    check("rd_data_hold", bus.readData, exp);
    bus.readReq = 1'b0;
    tick();
    check("rd_ack_fall", 32'(bus.readAck), 32'd0);
    check("rd_data_keep", bus.readData, exp);
    bus.ramAddress = 8'($urandom);
  endtask

  task automatic do_write(input logic [7:0] a, input logic [31:0] d);
    int n;
    bus.ramAddress = a; bus.writeData = d; bus.writeReq = 1'b1;
    n = 0;
    while (n < BOUND && !bus.writeAck) begin
      tick(); n++;
      check("wr_no_rd_ack", 32'(bus.readAck), 32'd0);
    end
    check("wr_latency", 32'(n), 32'(WL + 1));
    model_write(int'(a), d);
    tick();
    check("wr_ack_hold", 32'(bus.writeAck), 32'd1);
    bus.writeReq = 1'b0;
    tick();
    check("wr_ack_fall", 32'(bus.writeAck), 32'd0);
    bus.ramAddress = 8'($urandom); bus.writeData = $urandom;
  endtask

  // Raise a request, let it be accepted, then drop it before it can be acked.
  task automatic do_abort(input bit is_write, input logic [7:0] a);
    bus.ramAddress = a; bus.writeData = $urandom;
    if (is_write) bus.writeReq = 1'b1; else bus.readReq = 1'b1;
    tick();
    check("abort_busy", 32'(bus.busy), 32'd1);
    bus.writeReq = 1'b0; bus.readReq = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("abort_no_ack", {30'd0, bus.readAck, bus.writeAck}, 32'd0);
    end
    check("abort_idle", 32'(bus.busy), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] d;
    logic [7:0]  a, lb;
    reset = 1'b0;
    bus.ramAddress = '0; bus.writeData = '0; bus.readReq = 1'b0; bus.writeReq = 1'b0;
    bus.loadEn = 1'b0; bus.loadAddr = '0; bus.loadData = '0;
    repeat (3) tick();
    check("rst_read_ack", 32'(bus.readAck), 32'd0);
    check("rst_write_ack", 32'(bus.writeAck), 32'd0);
    check("rst_read_data", bus.readData, 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    reset = 1'b1;
    tick();

    for (int i = 0; i < RAMSIZE; i++) do_load(8'(i), 8'($urandom));
    for (int i = 0; i < 4; i++) do_load(8'(i), 8'(i + 1));

    // Preloaded word and the fixed test-plan values
    do_read(8'd0);
    check("preload_word", model_word(0), 32'h04030201);
    do_write(8'd8, 32'hDEADBEEF);
    do_read(8'd8);
    do_read(8'd9);
    do_write(8'd62, 32'h11223344);
    do_read(8'hFE);
    check("wrap_bytes", {model_mem[1], model_mem[0], model_mem[63], model_mem[62]}, 32'h11223344);

    // Both requests high: the write is serviced first, and the read waits for the write drop
    bus.ramAddress = 8'd20; bus.writeData = 32'hA5A55A5A;
    bus.writeReq = 1'b1; bus.readReq = 1'b1;
    begin
      int n;
      n = 0;
      while (n < BOUND && !bus.writeAck) begin
        tick(); n++;
        check("both_no_rd_ack", 32'(bus.readAck), 32'd0);
      end
      check("both_wr_latency", 32'(n), 32'(WL + 1));
      model_write(20, 32'hA5A55A5A);
      bus.writeReq = 1'b0;
      tick();
      check("both_wr_fall", 32'(bus.writeAck), 32'd0);
      check("both_rd_wait", 32'(bus.readAck), 32'd0);
      n = 0;
      while (n < BOUND && !bus.readAck) begin tick(); n++; end
      check("both_rd_latency", 32'(n), 32'(RL + 1));
      check("both_rd_data", bus.readData, 32'hA5A55A5A);
      bus.readReq = 1'b0;
      tick();
    end

    // Requests dropped before their ack, and a reset in the middle of a write
    do_abort(1'b0, 8'd4);
    do_abort(1'b1, 8'd4);
    do_read(8'd4);
    bus.ramAddress = 8'd24; bus.writeData = 32'hCAFEF00D; bus.writeReq = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    check("rst_mid_ack", {30'd0, bus.readAck, bus.writeAck}, 32'd0);
    check("rst_mid_data", bus.readData, 32'd0);
    check("rst_mid_busy", 32'(bus.busy), 32'd0);
    bus.writeReq = 1'b0; reset = 1'b1;
    tick();
    do_read(8'd24);

    // Load colliding with a write commit: the commit wins
    bus.ramAddress = 8'd30; bus.writeData = 32'h0BADC0DE; bus.writeReq = 1'b1;
    repeat (WL) tick();
    bus.loadEn = 1'b1; bus.loadAddr = 8'd30; bus.loadData = 8'h77;
    tick();
    bus.loadEn = 1'b0;
    check("coll_wr_ack", 32'(bus.writeAck), 32'd1);
    model_mem[30] = 8'h77;
    model_write(30, 32'h0BADC0DE);
    bus.writeReq = 1'b0;
    tick();
    do_read(8'd30);

    // Load during the read sample edge: the read returns the pre-load byte
    d = model_word(40);
    bus.ramAddress = 8'd40; bus.readReq = 1'b1;
    repeat (RL) tick();
    bus.loadEn = 1'b1; bus.loadAddr = 8'd41; bus.loadData = ~model_mem[41];
    tick();
    bus.loadEn = 1'b0;
    model_mem[41] = ~model_mem[41];
    check("coll_rd_ack", 32'(bus.readAck), 32'd1);
    check("coll_rd_data", bus.readData, d);
    bus.readReq = 1'b0;
    tick();
    do_read(8'd40);

    // CPU-style back-to-back traffic: a new request is raised one cycle after each drop
    for (int i = 0; i < 10; i++) begin
      a = 8'($urandom);
      if ($urandom_range(0, 1) == 1) do_write(a, $urandom);
      do_read(a);
    end

    // Random mix including loads and high address bits
    for (int i = 0; i < 40; i++) begin
      a = 8'($urandom); lb = 8'($urandom);
      case ($urandom_range(0, 2))
        0: do_load(a, lb);
        1: do_read(a);
        default: do_write(a, $urandom);
      endcase
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
